// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : sdram_arb_pkg                                               |
// | Purpose : Shared types and helpers for the SDRAM client arbiter.      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package sdram_arb_pkg;

  // Largest supported client count.
  localparam int MAX_N = 8;

  // Arbiter transaction states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } arb_state_t;

  // Width of a client index; never narrower than one bit.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arbiter_rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : rr_pick                                                     |
// | Purpose : Combinational round-robin picker with optional fixed top    |
// |           priority for client 0.                                      |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = grant_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  input  logic          prio0,
  output logic          found,
  output logic [GW-1:0] index
);

  localparam logic [GW-1:0] TOP_IDX = GW'(N - 1);

  logic [GW-1:0] cand;
  logic          hit;

  // Walk the ring from one past the last grant; first requester wins, client 0 overrides under prio0.
  always_comb begin
    cand  = last;
    hit   = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      cand = (cand == TOP_IDX) ? '0 : cand + 1'b1;
      if (!hit && req[cand]) begin
        hit   = 1'b1;
        index = cand;
      end
    end
    if (prio0 && req[0]) begin
      index = '0;
    end
    found = hit;
  end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : sdram_arbiter                                               |
// | Purpose : Serialises N request/ack clients onto the SDRAM controller  |
// |           read and write ports, one transaction at a time.            |
// |           Legal client count is 2..MAX_N.                             |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int AW    = 20,
  parameter int DW    = 16,
  parameter bit PRIO0 = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]    cli_req,
  input  logic [N-1:0]    cli_we,
  input  logic [N*AW-1:0] cli_addr,
  input  logic [N*DW-1:0] cli_wdata,
  output logic [N-1:0]    cli_ack,
  output logic [DW-1:0]   cli_rdata,
  output logic [AW-1:0] mem_rd_addr,
  output logic          mem_rd_ready,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          mem_rd_valid,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic          mem_wr_valid,
  input  logic          mem_wr_ready
);

  localparam int            GW         = grant_width(N);
  localparam logic [GW-1:0] LAST_RESET = GW'(N - 1);

  arb_state_t    state;
  arb_state_t    state_next;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] addr_arr  [N];
  logic [DW-1:0] wdata_arr [N];

  genvar i;
  for (i = 0; i < N; i++) begin : g_unpack
    assign addr_arr[i]  = cli_addr[i*AW +: AW];
    assign wdata_arr[i] = cli_wdata[i*DW +: DW];
  end

  rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .req   (cli_req),
    .last  (last_grant),
    .prio0 (PRIO0),
    .found (pick_found),
    .index (pick_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and controller/client outputs; requests are masked by the strobe so none repeats.
  always_comb begin
    state_next   = state;
    mem_rd_addr  = '0;
    mem_rd_ready = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    mem_wr_valid = 1'b0;
    cli_ack      = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = cli_we[pick_idx] ? WR : RD;
        end
      end
      RD: begin
        mem_rd_addr  = addr_q;
        mem_rd_ready = ~mem_rd_valid;
        if (mem_rd_valid) begin
          state_next = ACK;
        end
      end
      WR: begin
        mem_wr_addr  = addr_q;
        mem_wr_data  = wdata_q;
        mem_wr_valid = ~mem_wr_ready;
        if (mem_wr_ready) begin
          state_next = ACK;
        end
      end
      ACK: begin
        cli_ack[grant] = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's transaction, capture read data, and advance the round-robin pointer on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= LAST_RESET;
      addr_q     <= '0;
      wdata_q    <= '0;
      cli_rdata  <= '0;
    end else begin
      if (state == IDLE && pick_found) begin
        grant   <= pick_idx;
        addr_q  <= addr_arr[pick_idx];
        wdata_q <= wdata_arr[pick_idx];
      end
      if (state == RD && mem_rd_valid) begin
        cli_rdata <= mem_rd_data;
      end
      if (state == ACK) begin
        last_grant <= grant;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : tb_sdram_arbiter                                            |
// | Purpose : Self-checking bench; instance 0 is round-robin only,        |
// |           instance 1 gives client 0 fixed priority.                   |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_sdram_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;

  logic [N-1:0]    req   [2];
  logic [N-1:0]    we    [2];
  logic [N*AW-1:0] addr  [2];
  logic [N*DW-1:0] wdata [2];
  logic [N-1:0]    ack   [2];
  logic [DW-1:0]   rdata [2];
  logic [AW-1:0]   rd_addr  [2];
  logic [AW-1:0]   wr_addr  [2];
  logic [DW-1:0]   wr_data  [2];
  logic [DW-1:0]   rd_data  [2];
  logic            rd_ready [2];
  logic            rd_valid [2];
  logic            wr_valid [2];
  logic            wr_ready [2];

  int checks   = 0;
  int failures = 0;
  int last [2];
  int wr_count = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  sdram_arbiter #(.N(N), .AW(AW), .DW(DW), .PRIO0(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .cli_req(req[0]), .cli_we(we[0]), .cli_addr(addr[0]), .cli_wdata(wdata[0]),
    .cli_ack(ack[0]), .cli_rdata(rdata[0]),
    .mem_rd_addr(rd_addr[0]), .mem_rd_ready(rd_ready[0]),
    .mem_rd_data(rd_data[0]), .mem_rd_valid(rd_valid[0]),
    .mem_wr_addr(wr_addr[0]), .mem_wr_data(wr_data[0]),
    .mem_wr_valid(wr_valid[0]), .mem_wr_ready(wr_ready[0])
  );

  sdram_arbiter #(.N(N), .AW(AW), .DW(DW), .PRIO0(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .cli_req(req[1]), .cli_we(we[1]), .cli_addr(addr[1]), .cli_wdata(wdata[1]),
    .cli_ack(ack[1]), .cli_rdata(rdata[1]),
    .mem_rd_addr(rd_addr[1]), .mem_rd_ready(rd_ready[1]),
    .mem_rd_data(rd_data[1]), .mem_rd_valid(rd_valid[1]),
    .mem_wr_addr(wr_addr[1]), .mem_wr_data(wr_data[1]),
    .mem_wr_valid(wr_valid[1]), .mem_wr_ready(wr_ready[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: written words, otherwise an address-derived pattern.
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[DW-1:0] ^ 16'h3C3C;
  endfunction

  // Winner by the arbitration rules: client 0 first under priority, else the ring after the last grant.
  function automatic int predict(input int k);
    logic [N-1:0] r;
    if (k == 1 && req[k][0]) return 0;
    for (int j = 1; j <= N; j++) begin
      r = req[k] >> ((last[k] + j) % N);
      if (r[0]) return (last[k] + j) % N;
    end
    return -1;
  endfunction

  task automatic set_client(input int k, input int i, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k][i] = 1'b1;
    we[k][i]  = w;
    addr[k][i*AW +: AW]  = a;
    wdata[k][i*DW +: DW] = d;
  endtask

  // Play the controller for one transaction with the given response latency (cycles of request).
  task automatic serve(input int k, input int lat, output int who, output int rq);
    int n;
    int exp_w;
    bit isw;
    logic [N-1:0]  tv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [DW-1:0] er;
    exp_w = predict(k);
    if (exp_w < 0) begin
      $display("FAIL serve_no_request observed=none expected=request");
      $fatal(1, "bench error");
    end
    ea  = addr[k][exp_w*AW +: AW];
    ed  = wdata[k][exp_w*DW +: DW];
    tv  = we[k] >> exp_w;
    isw = tv[0];
    er  = mem_rd(ea);
    n = 0;
    while (!(rd_ready[k] || wr_valid[k]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", (n < 20), 1);
    chk("direction", wr_valid[k], isw);
    if (isw) begin
      chk("wr_addr", wr_addr[k], ea);
      chk("wr_data", wr_data[k], ed);
    end else begin
      chk("rd_addr", rd_addr[k], ea);
    end
    rq = 0;
    for (int c = 0; c < lat; c++) begin
      if (rd_ready[k] || wr_valid[k]) rq++;
      if (c < lat - 1) @(negedge clk);
    end
    chk("req_held", rq, lat);
    if (isw) begin
      wr_ready[k] = 1'b1;
      mem[wr_addr[k]] = wr_data[k];
      wr_count++;
    end else begin
      rd_valid[k] = 1'b1;
      rd_data[k]  = mem_rd(rd_addr[k]);
    end
    #1;
    chk("strobe_mask", {rd_ready[k], wr_valid[k]}, 0);
    @(negedge clk);
    rd_valid[k] = 1'b0;
    wr_ready[k] = 1'b0;
    rd_data[k]  = DW'($urandom);
    chk("ack", ack[k], 32'd1 << exp_w);
    if (!isw) chk("rdata", rdata[k], er);
    last[k] = exp_w;
    who = exp_w;
    @(negedge clk);
    chk("ack_one_cycle", ack[k], 0);
    chk("idle_no_req", {rd_ready[k], wr_valid[k]}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int rq;
    int cnt [N];
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; we[k] = '0; addr[k] = '0; wdata[k] = '0;
      rd_data[k] = '0; rd_valid[k] = 1'b0; wr_ready[k] = 1'b0;
      last[k] = N - 1;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values on both instances.
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack", ack[k], 0);
      chk("rst_rdata", rdata[k], 0);
      chk("rst_rd_ready", rd_ready[k], 0);
      chk("rst_wr_valid", wr_valid[k], 0);
      chk("rst_rd_addr", rd_addr[k], 0);
      chk("rst_wr_addr", wr_addr[k], 0);
      chk("rst_wr_data", wr_data[k], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Single read by client 2.
    mem[20'h00123] = 16'hBEEF;
    set_client(1, 2, 1'b0, 20'h00123, 16'h0000);
    @(negedge clk);
    chk("rd_latency", rd_ready[1], 1);
    serve(1, 2, who, rq);
    req[1][2] = 1'b0;
    chk("single_rd_who", who, 2);
    chk("single_rd_data", rdata[1], 16'hBEEF);

    // Stray strobes while idle are ignored and read data holds.
    rd_valid[1] = 1'b1; rd_data[1] = 16'h1234; wr_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stray_ack", ack[1], 0);
    chk("stray_rdata", rdata[1], 16'hBEEF);
    chk("stray_req", {rd_ready[1], wr_valid[1]}, 0);
    rd_valid[1] = 1'b0; wr_ready[1] = 1'b0;
    @(negedge clk);

    // Single write by client 1: one transaction only.
    wr_count = 0;
    set_client(1, 1, 1'b1, 20'h000FF, 16'h5A5A);
    serve(1, 3, who, rq);
    req[1][1] = 1'b0;
    chk("single_wr_who", who, 1);
    chk("single_wr_mem", mem_rd(20'h000FF), 16'h5A5A);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_valid[1]) wr_count++;
      chk("single_wr_quiet_ack", ack[1], 0);
    end
    chk("single_wr_count", wr_count, 1);

    // Double-issue guard: strobe in the first request cycle.
    set_client(1, 3, 1'b0, 20'h00200, 16'h0000);
    serve(1, 1, who, rq);
    req[1][3] = 1'b0;
    chk("guard_req_cnt", rq, 1);
    rq = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rd_ready[1]) rq++;
      chk("guard_no_ack", ack[1], 0);
    end
    chk("guard_no_reissue", rq, 0);

    // Reset one cycle into a read.
    set_client(1, 0, 1'b0, 20'h00042, 16'h0000);
    @(negedge clk);
    chk("rst_mid_in_rd", rd_ready[1], 1);
    reset = 1'b1;
    req[1][0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd_ready", rd_ready[1], 0);
    chk("rst_mid_ack", ack[1], 0);
    chk("rst_mid_rdata", rdata[1], 0);
    chk("rst_mid_rd_addr", rd_addr[1], 0);
    reset = 1'b0;
    last[0] = N - 1;
    last[1] = N - 1;
    @(negedge clk);
    chk("rst_mid_no_ack", ack[1], 0);
    set_client(1, 3, 1'b0, 20'h00077, 16'h0000);
    serve(1, 2, who, rq);
    req[1][3] = 1'b0;
    chk("rst_mid_after_who", who, 3);

    // Round-robin: all four clients hold read requests for 32 transactions.
    for (int i = 0; i < N; i++) begin
      set_client(0, i, 1'b0, 20'h00300 + AW'(i), 16'h0000);
      cnt[i] = 0;
    end
    for (int t = 0; t < 8 * N; t++) begin
      serve(0, int'($urandom_range(1, 4)), who, rq);
      chk("rr_order", who, t % N);
      if (who >= 0 && who < N) cnt[who]++;
    end
    req[0] = '0;
    for (int i = 0; i < N; i++) chk("rr_count", cnt[i], 8);

    // Fixed priority: client 0 holds the bus until it drops, then 1, then 3.
    set_client(1, 1, 1'b0, 20'h00401, 16'h0000);
    set_client(1, 3, 1'b1, 20'h00403, 16'hC0DE);
    set_client(1, 0, 1'b0, 20'h00400, 16'h0000);
    for (int t = 0; t < 3; t++) begin
      serve(1, 2, who, rq);
      chk("prio_client0", who, 0);
    end
    req[1][0] = 1'b0;
    serve(1, 2, who, rq);
    chk("prio_then_1", who, 1);
    req[1][1] = 1'b0;
    serve(1, 2, who, rq);
    chk("prio_then_3", who, 3);
    req[1][3] = 1'b0;
    @(negedge clk);

    // Randomised mixed traffic on both instances against the model.
    for (int r = 0; r < 60; r++) begin
      int k;
      k = int'($urandom_range(0, 1));
      if (req[k] == '0) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 1) == 1)
            set_client(k, i, 1'($urandom_range(0, 1)), 20'h00100 + AW'($urandom_range(0, 7)), DW'($urandom));
        end
        if (req[k] == '0)
          set_client(k, int'($urandom_range(0, N - 1)), 1'b0, 20'h00100, 16'h0000);
      end
      serve(k, int'($urandom_range(1, 4)), who, rq);
      if ($urandom_range(0, 3) != 0) req[k][who] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
